// File: rtl/sram_like_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sram_like_responder_pkg                                      |
// | Description : Shared constants, size encoding and byte-lane merge helper   |
// |               for the SRAM-like req/addr_ok/data_ok responder.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package sram_like_responder_pkg;

  // Transfer size encoding on the size port; write lanes are governed by wstrb.
  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  // Replace only the byte lanes whose strobe bit is set.
  function automatic logic [DATA_W-1:0] merge_wstrb(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] new_word,
    input logic [STRB_W-1:0] strb
  );
    logic [DATA_W-1:0] merged;
    merged = old_word;
    for (int i = 0; i < STRB_W; i++) begin
      if (strb[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_like_resp_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sram_like_resp_queue                                         |
// | Description : In-order circular response queue with a per-entry latency   |
// |               timer. The head is ready to retire when its timer is zero.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sram_like_resp_queue
  import sram_like_responder_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic              push_is_wr_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic              head_valid_o,
  output logic              head_timer_zero_o,
  output logic [DATA_W-1:0] head_data_o,
  output logic              head_is_wr_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  logic              valid_q [DEPTH];
  logic              valid_d [DEPTH];
  logic              is_wr_q [DEPTH];
  logic              is_wr_d [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];
  logic [DATA_W-1:0] data_d  [DEPTH];
  logic [TW-1:0]     timer_q [DEPTH];
  logic [TW-1:0]     timer_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  // Depth need not be a power of two, so wrap by explicit compare-and-clear.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
  endfunction

  // Next-state: age all timers, retire the head on pop, append on push.
  always_comb begin
    valid_d  = valid_q;
    is_wr_d  = is_wr_q;
    data_d   = data_q;
    timer_d  = timer_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (timer_q[i] != '0)) timer_d[i] = timer_q[i] - TW'(1);
    end
    if (pop_i) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = ptr_next(rd_ptr_q);
    end
    // When full, push reuses the slot being popped this edge; push wins.
    if (push_i) begin
      valid_d[wr_ptr_q] = 1'b1;
      is_wr_d[wr_ptr_q] = push_is_wr_i;
      data_d[wr_ptr_q]  = push_data_i;
      timer_d[wr_ptr_q] = TW'(LATENCY - 1);
      wr_ptr_d          = ptr_next(wr_ptr_q);
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Queue state register; reset drops everything in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        is_wr_q[i] <= 1'b0;
        data_q[i]  <= '0;
        timer_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      is_wr_q  <= is_wr_d;
      data_q   <= data_d;
      timer_q  <= timer_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign full_o            = (count_q == CW'(DEPTH));
  assign head_valid_o      = valid_q[rd_ptr_q];
  assign head_timer_zero_o = (timer_q[rd_ptr_q] == '0);
  assign head_data_o       = data_q[rd_ptr_q];
  assign head_is_wr_o      = is_wr_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/sram_like_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sram_like_responder                                          |
// | Description : SRAM-like slave: word-addressed memory, up to OUTSTANDING    |
// |               accepted requests, in-order data_ok after a fixed LATENCY.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sram_like_responder
  import sram_like_responder_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int OUTSTANDING = 2,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [ADDR_W-1:0] idx;
  logic              hs;
  logic              q_full;
  logic              q_head_valid;
  logic              q_head_timer_zero;
  logic [DATA_W-1:0] q_head_data;
  logic              q_head_is_wr;
  logic              unused_bits;

  // Upper address bits wrap; addr[1:0] and size are left to the master.
  assign idx         = addr[ADDR_W+1:2];
  assign unused_bits = ^{size, addr[31:ADDR_W+2], addr[1:0]};

  // Accept whenever a slot is free or one retires this cycle; independent of req.
  assign addr_ok = ~q_full | data_ok;
  assign hs      = req & addr_ok;
  assign data_ok = q_head_valid & q_head_timer_zero;
  assign rdata   = (data_ok & ~q_head_is_wr) ? q_head_data : '0;

  // Memory is not reset; writes merge byte lanes at the handshake edge.
  always_ff @(posedge clk) begin
    if (hs && wr) mem_q[idx] <= merge_wstrb(mem_q[idx], wdata, wstrb);
  end

  sram_like_resp_queue #(
    .DEPTH   (OUTSTANDING),
    .LATENCY (LATENCY)
  ) u_queue (
    .clk               (clk),
    .reset             (reset),
    .push_i            (hs),
    .push_is_wr_i      (wr),
    .push_data_i       (wr ? '0 : mem_q[idx]),
    .pop_i             (data_ok),
    .full_o            (q_full),
    .head_valid_o      (q_head_valid),
    .head_timer_zero_o (q_head_timer_zero),
    .head_data_o       (q_head_data),
    .head_is_wr_o      (q_head_is_wr)
  );

endmodule
`default_nettype wire

// File: tb/tb_sram_like_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sram_like_responder                                       |
// | Description : Self-checking bench: table of requests with scoreboarded     |
// |               in-order responses, plus hand-written corner sequences.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_sram_like_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, wr0, req1, wr1;
  logic [1:0]  size0, size1;
  logic [3:0]  strb0, strb1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        ok0, dok0, ok1, dok1;
  logic [31:0] rdata0, rdata1;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sb0[$];
  exp_t sb1[$];

  typedef struct {
    logic        w;
    logic [3:0]  s;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] e;
  } vec_t;
  vec_t vecs[12];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_like_responder #(.ADDR_W(12), .OUTSTANDING(2), .LATENCY(2)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .wr(wr0), .size(size0), .wstrb(strb0),
    .addr(addr0), .wdata(wdata0), .addr_ok(ok0), .data_ok(dok0), .rdata(rdata0)
  );

  sram_like_responder #(.ADDR_W(12), .OUTSTANDING(2), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .req(req1), .wr(wr1), .size(size1), .wstrb(strb1),
    .addr(addr1), .wdata(wdata1), .addr_ok(ok1), .data_ok(dok1), .rdata(rdata1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response monitors: every data_ok must match the oldest expectation, on its due cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (dok0) begin
        if (sb0.size() == 0) chk("d0_unexpected_data_ok", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = sb0.pop_front();
          chk("d0_rdata", rdata0, e.data);
          chk("d0_latency_cycle", 32'(cyc), 32'(e.due));
        end
      end else chk("d0_rdata_idle", rdata0, 32'd0);
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (dok1) begin
        if (sb1.size() == 0) chk("d1_unexpected_data_ok", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = sb1.pop_front();
          chk("d1_rdata", rdata1, e.data);
          chk("d1_latency_cycle", 32'(cyc), 32'(e.due));
        end
      end else chk("d1_rdata_idle", rdata1, 32'd0);
    end
  end

  // Drive one request and hold it until accepted; the expectation is queued at acceptance.
  task automatic issue(input int sel, input logic w, input logic [3:0] s,
                       input logic [31:0] a, input logic [31:0] d, input logic [31:0] e,
                       output int waited);
    bit   got;
    exp_t x;
    waited = 0;
    got    = 1'b0;
    if (sel == 0) begin
      req0 = 1'b1; wr0 = w; strb0 = s; addr0 = a; wdata0 = d;
    end else begin
      req1 = 1'b1; wr1 = w; strb1 = s; addr1 = a; wdata1 = d;
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if ((sel == 0) ? ok0 : ok1) begin
        got    = 1'b1;
        x.data = e;
        if (sel == 0) begin
          x.due = cyc + 2;
          chk("d0_outstanding_limit", 32'(sb0.size() - (dok0 ? 1 : 0) < 2), 32'd1);
          sb0.push_back(x);
        end else begin
          x.due = cyc + 1;
          sb1.push_back(x);
        end
        break;
      end
      waited++;
    end
    if (!got) chk("addr_ok_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && (sb0.size() != 0 || sb1.size() != 0); k++) @(posedge clk);
    #1;
    chk("d0_all_responses_seen", 32'(sb0.size()), 32'd0);
    chk("d1_all_responses_seen", 32'(sb1.size()), 32'd0);
  endtask

  initial begin
    int w;
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    reset = 1'b1;
    req0 = 1'b0; wr0 = 1'b0; size0 = 2'd2; strb0 = 4'h0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; wr1 = 1'b0; size1 = 2'd2; strb1 = 4'h0; addr1 = '0; wdata1 = '0;

    //         w     strb     addr           wdata          expected rdata
    vecs[0]  = '{1'b1, 4'hF, 32'h0000_0010, 32'h1234_5678, 32'h0};
    vecs[1]  = '{1'b0, 4'h0, 32'h0000_0010, 32'h0,         32'h1234_5678};
    vecs[2]  = '{1'b1, 4'hF, 32'h0000_001C, 32'h1111_1111, 32'h0};
    vecs[3]  = '{1'b1, 4'h5, 32'h0000_001C, 32'hAABB_CCDD, 32'h0};
    vecs[4]  = '{1'b0, 4'h0, 32'h0000_001C, 32'h0,         32'h11BB_11DD};
    vecs[5]  = '{1'b1, 4'hF, 32'h0000_4008, 32'hCAFE_F00D, 32'h0};
    vecs[6]  = '{1'b0, 4'h0, 32'h0000_0008, 32'h0,         32'hCAFE_F00D};
    vecs[7]  = '{1'b0, 4'h0, 32'h0000_4008, 32'h0,         32'hCAFE_F00D};
    vecs[8]  = '{1'b1, 4'h0, 32'h0000_0010, 32'hFFFF_FFFF, 32'h0};
    vecs[9]  = '{1'b0, 4'h0, 32'h0000_0010, 32'h0,         32'h1234_5678};
    vecs[10] = '{1'b1, 4'h8, 32'h0000_0013, 32'h9900_0000, 32'h0};
    vecs[11] = '{1'b0, 4'h0, 32'h0000_0011, 32'h0,         32'h9934_5678};

    // Reset state
    @(negedge clk);
    chk("rst_d0_addr_ok", 32'(ok0), 32'd1);
    chk("rst_d0_data_ok", 32'(dok0), 32'd0);
    chk("rst_d0_rdata", rdata0, 32'd0);
    chk("rst_d1_addr_ok", 32'(ok1), 32'd1);
    chk("rst_d1_data_ok", 32'(dok1), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Table: writes, strobed writes, aliasing, wstrb=0, sub-word address bits
    for (int i = 0; i < 12; i++) begin
      issue(0, vecs[i].w, vecs[i].s, vecs[i].a, vecs[i].d, vecs[i].e, w);
      idle();
      repeat (i % 2) @(posedge clk);
      #1;
    end
    drain();

    // Held req for 4 reads: accepted on consecutive cycles, in-order responses
    issue(0, 1'b0, 4'h0, 32'h10, 32'h0, 32'h9934_5678, w);
    issue(0, 1'b0, 4'h0, 32'h1C, 32'h0, 32'h11BB_11DD, w);
    chk("b2b_wait_2", 32'(w), 32'd0);
    issue(0, 1'b0, 4'h0, 32'h08, 32'h0, 32'hCAFE_F00D, w);
    chk("b2b_wait_3", 32'(w), 32'd0);
    issue(0, 1'b0, 4'h0, 32'h10, 32'h0, 32'h9934_5678, w);
    chk("b2b_wait_4", 32'(w), 32'd0);
    idle();
    drain();

    // LATENCY=1: preload, then continuous reads with addr_ok never dropping
    for (int i = 0; i < 4; i++) issue(1, 1'b1, 4'hF, 32'(i * 4), 32'hA5A5_0000 + 32'(i), 32'h0, w);
    for (int i = 0; i < 6; i++) begin
      issue(1, 1'b0, 4'h0, 32'((i % 4) * 4), 32'h0, 32'hA5A5_0000 + 32'(i % 4), w);
      chk("lat1_wait", 32'(w), 32'd0);
    end
    idle();
    drain();

    // Reset with two reads in flight: responses dropped, memory kept
    issue(0, 1'b0, 4'h0, 32'h10, 32'h0, 32'h0, w);
    issue(0, 1'b0, 4'h0, 32'h1C, 32'h0, 32'h0, w);
    idle();
    reset = 1'b1;
    sb0.delete();
    @(negedge clk);
    chk("midrst_addr_ok", 32'(ok0), 32'd1);
    chk("midrst_data_ok", 32'(dok0), 32'd0);
    chk("midrst_rdata", rdata0, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("postrst_data_ok", 32'(dok0), 32'd0);
      chk("postrst_addr_ok", 32'(ok0), 32'd1);
    end
    @(posedge clk);
    #1;
    issue(0, 1'b0, 4'h0, 32'h10, 32'h0, 32'h9934_5678, w);
    issue(0, 1'b0, 4'h0, 32'h1C, 32'h0, 32'h11BB_11DD, w);
    idle();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
